vtgen: RTL and testbench

Parametrised video timing and scan-address generator. It merges display timing (counters, sync, blanking) with scan-fetch address generation and adds configurable mode timing, sync polarity, integer pixel/line scaling, runtime line stride and tear-free double-buffered frame base. It runs in the PixelClk domain. It drives the video DACs' sync/blank and pushes read requests to the memory arbiter ahead of display.

---
 rtl/vtgen.sv | 228 ++++++++++++++++++++++
 tb/tb_vtgen.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtgen.sv
// vtgen: video timing and scan-address generator in the PixelClk domain.
// A fetch counter pair runs FETCHLEAD cycles ahead of a display counter pair.
// Display counters drive sync/blank/position. Fetch counters drive memory read
// requests, with integer pixel/line replication, a runtime line stride and a
// double-buffered frame base that swaps only at the fetch frame boundary.
//
// Handshake: FetchReq is a single-cycle request with no back-pressure. The
// arbiter must take it in the cycle it is presented. FetchAddr is meaningful
// only while FetchReq is high and is held at zero otherwise.
module vtgen #(
    parameter int XWIDTH      = 10,
    parameter int YWIDTH      = 10,
    parameter int AWIDTH      = 19,
    parameter int HACT        = 640,
    parameter int HFP         = 16,
    parameter int HSW         = 96,
    parameter int HBP         = 48,
    parameter int VACT        = 480,
    parameter int VFP         = 10,
    parameter int VSW         = 2,
    parameter int VBP         = 33,
    parameter bit HSPOL       = 1'b0,
    parameter bit VSPOL       = 1'b0,
    parameter int PIXPERFETCH = 2,
    parameter int XSCALE      = 1,
    parameter int YSCALE      = 1,
    parameter int FETCHLEAD   = 4,
    parameter int BASEINIT    = 0
) (
    input  logic              PixelClk,
    input  logic              ResetN,
    input  logic              VideoEn,
    input  logic [AWIDTH-1:0] LineStride,
    input  logic [AWIDTH-1:0] BaseAddrIn,
    input  logic              BaseLoad,
    output logic              BasePending,
    output logic [XWIDTH-1:0] PixelCnt,
    output logic [YWIDTH-1:0] LineCnt,
    output logic              HSync,
    output logic              VSync,
    output logic              Blank,
    output logic              FrameStart,
    output logic              FetchReq,
    output logic [AWIDTH-1:0] FetchAddr
);

    localparam int HTOTAL   = HACT + HFP + HSW + HBP;
    localparam int VTOTAL   = VACT + VFP + VSW + VBP;
    localparam int FETCHDIV = PIXPERFETCH * XSCALE;

    // Typed timing constants so every compare is width-matched.
    localparam logic [XWIDTH-1:0] HMAX      = XWIDTH'(HTOTAL - 1);
    localparam logic [XWIDTH-1:0] HACTV     = XWIDTH'(HACT);
    localparam logic [XWIDTH-1:0] HSSTART   = XWIDTH'(HACT + HFP);
    localparam logic [XWIDTH-1:0] HSEND     = XWIDTH'(HACT + HFP + HSW);
    localparam logic [XWIDTH-1:0] HDISPINIT = XWIDTH'(HTOTAL - FETCHLEAD);
    localparam logic [YWIDTH-1:0] VMAX      = YWIDTH'(VTOTAL - 1);
    localparam logic [YWIDTH-1:0] VACTV     = YWIDTH'(VACT);
    localparam logic [YWIDTH-1:0] VSSTART   = YWIDTH'(VACT + VFP);
    localparam logic [YWIDTH-1:0] VSEND     = YWIDTH'(VACT + VFP + VSW);
    localparam logic [YWIDTH-1:0] VDISPINIT = YWIDTH'(VTOTAL - 1);
    localparam logic [XWIDTH-1:0] DIVMAX    = XWIDTH'(FETCHDIV - 1);
    localparam logic [YWIDTH-1:0] YREPMAX   = YWIDTH'(YSCALE - 1);
    localparam logic [AWIDTH-1:0] BASERST   = AWIDTH'(BASEINIT);

    // Fetch and display counter pairs.
    logic [XWIDTH-1:0] fetchX;
    logic [YWIDTH-1:0] fetchY;
    logic [XWIDTH-1:0] dispX;
    logic [YWIDTH-1:0] dispY;

    // Divider-free address generation: subCnt counts replicated pixels
    // within one fetched byte, byteCnt counts bytes along the line, yRep
    // counts replicated source lines.
    logic [XWIDTH-1:0] subCnt;
    logic [XWIDTH-1:0] byteCnt;
    logic [YWIDTH-1:0] yRep;

    // Address bases and the double-buffer pending register.
    logic [AWIDTH-1:0] lineBase;
    logic [AWIDTH-1:0] frameBase;
    logic [AWIDTH-1:0] pendBase;
    logic              pendFlag;

    // Decoded conditions.
    logic              fetchXWrap;
    logic              fetchYWrap;
    logic              fetchFrameEnd;
    logic              dispXWrap;
    logic              dispYWrap;
    logic [AWIDTH-1:0] nextFrameBase;
    logic              fetchHit;
    logic [AWIDTH-1:0] fetchAddrNext;
    logic              dispActive;
    logic              hSyncActive;
    logic              vSyncActive;
    logic              frameOrigin;

    // Combinational decode of counter state into next-cycle outputs.
    always_comb begin
        fetchXWrap    = (fetchX == HMAX);
        fetchYWrap    = (fetchY == VMAX);
        fetchFrameEnd = fetchXWrap && fetchYWrap;
        dispXWrap     = (dispX == HMAX);
        dispYWrap     = (dispY == VMAX);
        // The base that the next fetch frame starts from.
        nextFrameBase = pendFlag ? pendBase : frameBase;
        fetchHit      = (fetchX < HACTV) && (fetchY < VACTV) && VideoEn
                        && (subCnt == '0);
        fetchAddrNext = lineBase + AWIDTH'(byteCnt);
        dispActive    = (dispX < HACTV) && (dispY < VACTV) && VideoEn;
        hSyncActive   = (dispX >= HSSTART) && (dispX < HSEND);
        vSyncActive   = (dispY >= VSSTART) && (dispY < VSEND);
        frameOrigin   = (dispX == '0) && (dispY == '0);
    end

    // Fetch position: raster scan that leads the display by FETCHLEAD.
    always_ff @(posedge PixelClk) begin
        if (!ResetN) begin
            fetchX <= '0;
            fetchY <= '0;
        end else if (fetchXWrap) begin
            fetchX <= '0;
            fetchY <= fetchYWrap ? '0 : fetchY + 1'b1;
        end else begin
            fetchX <= fetchX + 1'b1;
        end
    end

    // Display position: same raster, started FETCHLEAD cycles behind fetch.
    always_ff @(posedge PixelClk) begin
        if (!ResetN) begin
            dispX <= HDISPINIT;
            dispY <= VDISPINIT;
        end else if (dispXWrap) begin
            dispX <= '0;
            dispY <= dispYWrap ? '0 : dispY + 1'b1;
        end else begin
            dispX <= dispX + 1'b1;
        end
    end

    // Horizontal replication/byte counters, restarted every fetch line.
    always_ff @(posedge PixelClk) begin
        if (!ResetN || fetchXWrap) begin
            subCnt  <= '0;
            byteCnt <= '0;
        end else if (subCnt == DIVMAX) begin
            subCnt  <= '0;
            byteCnt <= byteCnt + 1'b1;
        end else begin
            subCnt <= subCnt + 1'b1;
        end
    end

    // Vertical replication counter, restarted every fetch frame.
    always_ff @(posedge PixelClk) begin
        if (!ResetN) begin
            yRep <= '0;
        end else if (fetchXWrap) begin
            if (fetchYWrap || (yRep == YREPMAX)) begin
                yRep <= '0;
            end else begin
                yRep <= yRep + 1'b1;
            end
        end
    end

    // Line base: reloaded from the (possibly swapped) frame base at the frame
    // boundary, stepped by LineStride after the last replica of a source line.
    always_ff @(posedge PixelClk) begin
        if (!ResetN) begin
            lineBase <= BASERST;
        end else if (fetchXWrap) begin
            if (fetchYWrap) begin
                lineBase <= nextFrameBase;
            end else if ((fetchY < VACTV) && (yRep == YREPMAX)) begin
                lineBase <= lineBase + LineStride;
            end
        end
    end

    // Double buffer: a load always wins the pending slot, and a swap at the
    // frame boundary consumes the value that was pending before that edge.
    always_ff @(posedge PixelClk) begin
        if (!ResetN) begin
            frameBase <= BASERST;
            pendBase  <= '0;
            pendFlag  <= 1'b0;
        end else begin
            if (fetchFrameEnd && pendFlag) begin
                frameBase <= pendBase;
            end
            if (BaseLoad) begin
                pendBase <= BaseAddrIn;
                pendFlag <= 1'b1;
            end else if (fetchFrameEnd) begin
                pendFlag <= 1'b0;
            end
        end
    end

    assign BasePending = pendFlag;

    // Registered outputs, all reflecting the previous cycle's counter state.
    always_ff @(posedge PixelClk) begin
        if (!ResetN) begin
            HSync      <= ~HSPOL;
            VSync      <= ~VSPOL;
            Blank      <= 1'b1;
            FrameStart <= 1'b0;
            FetchReq   <= 1'b0;
            FetchAddr  <= '0;
            PixelCnt   <= '0;
            LineCnt    <= '0;
        end else begin
            HSync      <= hSyncActive ? HSPOL : ~HSPOL;
            VSync      <= vSyncActive ? VSPOL : ~VSPOL;
            Blank      <= ~dispActive;
            FrameStart <= frameOrigin;
            FetchReq   <= fetchHit;
            FetchAddr  <= fetchHit ? fetchAddrNext : '0;
            PixelCnt   <= dispX;
            LineCnt    <= dispY;
        end
    end

endmodule

// File: tb/tb_vtgen.sv
// tb_vtgen: two vtgen instances (different scaling, polarity and reset base)
// on a small raster, checked every cycle against a positional reference model.
`timescale 1ns/1ps
module tb_vtgen;

    localparam int XW = 10;
    localparam int YW = 10;
    localparam int AW = 10;
    localparam int HACT = 16;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 3;
    localparam int VACT = 6;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int FL = 4;
    localparam int HT = HACT + HFP + HSW + HBP;
    localparam int VT = VACT + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam int AMOD = 1 << AW;

    // Instance 0: PIXPERFETCH=2, XSCALE=1, YSCALE=1, syncs active-low, base 0.
    // Instance 1: PIXPERFETCH=2, XSCALE=2, YSCALE=2, syncs active-high, base 5.
    localparam int K0 = 2;
    localparam int K1 = 4;
    localparam int YS0 = 1;
    localparam int YS1 = 2;
    localparam int BASE0 = 0;
    localparam int BASE1 = 5;

    // Clock and reset.
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetN = 1'b0;
    logic          videoEn = 1'b0;
    logic          baseLoad = 1'b0;
    logic [AW-1:0] lineStride = '0;
    logic [AW-1:0] baseAddrIn = '0;

    logic          pend0, pend1, hs0, hs1, vs0, vs1, blank0, blank1;
    logic          fs0, fs1, req0, req1;
    logic [XW-1:0] px0, px1;
    logic [YW-1:0] ln0, ln1;
    logic [AW-1:0] addr0, addr1;

    vtgen #(.XWIDTH(XW), .YWIDTH(YW), .AWIDTH(AW), .HACT(HACT), .HFP(HFP),
            .HSW(HSW), .HBP(HBP), .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP),
            .HSPOL(1'b0), .VSPOL(1'b0), .PIXPERFETCH(2), .XSCALE(1), .YSCALE(1),
            .FETCHLEAD(FL), .BASEINIT(BASE0)) dut0 (
        .PixelClk(clk), .ResetN(resetN), .VideoEn(videoEn),
        .LineStride(lineStride), .BaseAddrIn(baseAddrIn), .BaseLoad(baseLoad),
        .BasePending(pend0), .PixelCnt(px0), .LineCnt(ln0), .HSync(hs0),
        .VSync(vs0), .Blank(blank0), .FrameStart(fs0), .FetchReq(req0),
        .FetchAddr(addr0));

    vtgen #(.XWIDTH(XW), .YWIDTH(YW), .AWIDTH(AW), .HACT(HACT), .HFP(HFP),
            .HSW(HSW), .HBP(HBP), .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP),
            .HSPOL(1'b1), .VSPOL(1'b1), .PIXPERFETCH(2), .XSCALE(2), .YSCALE(2),
            .FETCHLEAD(FL), .BASEINIT(BASE1)) dut1 (
        .PixelClk(clk), .ResetN(resetN), .VideoEn(videoEn),
        .LineStride(lineStride), .BaseAddrIn(baseAddrIn), .BaseLoad(baseLoad),
        .BasePending(pend1), .PixelCnt(px1), .LineCnt(ln1), .HSync(hs1),
        .VSync(vs1), .Blank(blank1), .FrameStart(fs1), .FetchReq(req1),
        .FetchAddr(addr1));

    // Scoreboard counters.
    int checkCnt = 0;
    int passCnt = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one linear raster position per cycle, fetch and
    // display positions and addresses derived arithmetically from it.
    int pos = 0;
    int curBase[2];
    int pendVal[2];
    bit pendFlag[2];
    bit eReq[2], eHs[2], eVs[2], ePend[2];
    int eAddr[2];
    bit eBlank, eFs;
    int ePx, eLn;

    function automatic int kOf(input int i);
        return (i == 0) ? K0 : K1;
    endfunction

    function automatic int ysOf(input int i);
        return (i == 0) ? YS0 : YS1;
    endfunction

    function automatic int baseOf(input int i);
        return (i == 0) ? BASE0 : BASE1;
    endfunction

    task automatic modelEdge();
        int fx, fy, dp, dx, dy;
        bit hAct, vAct, pol;
        if (!resetN) begin
            for (int i = 0; i < 2; i++) begin
                pol = (i == 1);
                eReq[i] = 1'b0;
                eAddr[i] = 0;
                eHs[i] = !pol;
                eVs[i] = !pol;
                curBase[i] = baseOf(i);
                pendVal[i] = 0;
                pendFlag[i] = 1'b0;
                ePend[i] = 1'b0;
            end
            eBlank = 1'b1;
            eFs = 1'b0;
            ePx = 0;
            eLn = 0;
            pos = 0;
        end else begin
            fx = pos % HT;
            fy = pos / HT;
            dp = (pos - FL + FT) % FT;
            dx = dp % HT;
            dy = dp / HT;
            eBlank = !(dx < HACT && dy < VACT && videoEn);
            eFs = (dx == 0 && dy == 0);
            ePx = dx;
            eLn = dy;
            hAct = (dx >= HACT + HFP) && (dx < HACT + HFP + HSW);
            vAct = (dy >= VACT + VFP) && (dy < VACT + VFP + VSW);
            for (int i = 0; i < 2; i++) begin
                pol = (i == 1);
                eHs[i] = hAct ? pol : !pol;
                eVs[i] = vAct ? pol : !pol;
                eReq[i] = (fx < HACT) && (fy < VACT) && videoEn && (fx % kOf(i) == 0);
                eAddr[i] = (curBase[i] + (fy / ysOf(i)) * int'(lineStride) + fx / kOf(i)) % AMOD;
                if (pos == FT - 1 && pendFlag[i]) begin
                    curBase[i] = pendVal[i];
                    pendFlag[i] = 1'b0;
                end
                if (baseLoad) begin
                    pendVal[i] = int'(baseAddrIn);
                    pendFlag[i] = 1'b1;
                end
                ePend[i] = pendFlag[i];
            end
            pos = (pos + 1) % FT;
        end
    endtask

    task automatic compareAll();
        checkEq("blank0", 32'(blank0), 32'(eBlank));
        checkEq("blank1", 32'(blank1), 32'(eBlank));
        checkEq("frameStart0", 32'(fs0), 32'(eFs));
        checkEq("frameStart1", 32'(fs1), 32'(eFs));
        checkEq("pixelCnt0", 32'(px0), 32'(ePx));
        checkEq("lineCnt1", 32'(ln1), 32'(eLn));
        checkEq("hSync0", 32'(hs0), 32'(eHs[0]));
        checkEq("hSync1", 32'(hs1), 32'(eHs[1]));
        checkEq("vSync0", 32'(vs0), 32'(eVs[0]));
        checkEq("vSync1", 32'(vs1), 32'(eVs[1]));
        checkEq("fetchReq0", 32'(req0), 32'(eReq[0]));
        checkEq("fetchReq1", 32'(req1), 32'(eReq[1]));
        checkEq("basePending0", 32'(pend0), 32'(ePend[0]));
        checkEq("basePending1", 32'(pend1), 32'(ePend[1]));
        if (eReq[0]) checkEq("fetchAddr0", 32'(addr0), 32'(eAddr[0]));
        if (eReq[1]) checkEq("fetchAddr1", 32'(addr1), 32'(eAddr[1]));
        if (!resetN) begin
            checkEq("rstAddr0", 32'(addr0), 32'd0);
            checkEq("rstPixelCnt1", 32'(px1), 32'd0);
        end
    endtask

    // One clock: model and DUT see the same inputs at the edge, compare after.
    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    // Driver. mode 0: enabled, no loads; 1: enabled, random loads;
    // 2: random VideoEn and loads; 3: VideoEn low. Stride only moves in vblank.
    task automatic setInputs(input int mode);
        baseAddrIn = AW'($urandom_range(0, AMOD - 1));
        baseLoad = (mode == 1 || mode == 2) && ($urandom_range(0, 99) < 3);
        if (mode == 2) videoEn = 1'($urandom_range(0, 1));
        else videoEn = (mode != 3);
        if (pos == VACT * HT + 1) lineStride = AW'($urandom_range(0, AMOD - 1));
    endtask

    task automatic runCycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            setInputs(mode);
            tick();
        end
    endtask

    task automatic runTo(input int target, input int mode);
        for (int i = 0; i < FT && pos != target; i++) begin
            setInputs(mode);
            tick();
        end
    endtask

    int waitCnt;
    int reqCnt0, reqCnt1, blankLowCnt, blankHighCnt, hsLowCnt, vsLowCnt;

    task automatic countFrame(input int mode);
        reqCnt0 = 0; reqCnt1 = 0; blankLowCnt = 0; blankHighCnt = 0;
        hsLowCnt = 0; vsLowCnt = 0;
        for (int i = 0; i < FT; i++) begin
            setInputs(mode);
            tick();
            reqCnt0 += int'(req0);
            reqCnt1 += int'(req1);
            blankLowCnt += int'(!blank0);
            blankHighCnt += int'(blank1);
            hsLowCnt += int'(!hs0);
            vsLowCnt += int'(!vs0);
        end
    endtask

    initial begin
        lineStride = AW'(HACT / K0);
        // Reset held for a few cycles.
        resetN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setInputs(0);
            tick();
        end
        resetN = 1'b1;

        // Release: first request at the reset base, FrameStart FETCHLEAD+1 later.
        setInputs(0);
        tick();
        checkEq("firstReq0", 32'(req0), 32'd1);
        checkEq("firstAddr1", 32'(addr1), 32'(BASE1));
        waitCnt = 1;
        while (!fs0 && waitCnt < 20) begin
            setInputs(0);
            tick();
            waitCnt++;
        end
        checkEq("frameStartLatency", 32'(waitCnt), 32'(FL + 1));
        checkEq("frameStartLine", 32'(ln0), 32'd0);

        // Steady-state frame statistics.
        countFrame(0);
        checkEq("reqPerFrame0", 32'(reqCnt0), 32'((HACT / K0) * VACT));
        checkEq("reqPerFrame1", 32'(reqCnt1), 32'((HACT / K1) * VACT));
        checkEq("blankLowCnt", 32'(blankLowCnt), 32'(HACT * VACT));
        checkEq("hsLowCnt", 32'(hsLowCnt), 32'(HSW * VT));
        checkEq("vsLowCnt", 32'(vsLowCnt), 32'(VSW * HT));

        // Random base loads and stride changes.
        runCycles(3 * FT, 1);

        // Swap-cycle collision: pending A, load B exactly at the frame end.
        runTo(FT / 2, 0);
        setInputs(0);
        baseLoad = 1'b1;
        baseAddrIn = AW'(10'h100);
        tick();
        checkEq("collPendSet", 32'(pend0), 32'd1);
        runTo(FT - 1, 0);
        setInputs(0);
        baseLoad = 1'b1;
        baseAddrIn = AW'(10'h200);
        tick();
        checkEq("collPendKept", 32'(pend1), 32'd1);
        setInputs(0);
        tick();
        checkEq("collFirstAddr0", 32'(addr0), 32'h100);
        runCycles(2 * FT - 1, 0);
        checkEq("collPendClear", 32'(pend0), 32'd0);

        // VideoEn low for one whole frame.
        countFrame(3);
        checkEq("disReqCnt", 32'(reqCnt0 + reqCnt1), 32'd0);
        checkEq("disBlankCnt", 32'(blankHighCnt), 32'(FT));
        checkEq("disHsLowCnt", 32'(hsLowCnt), 32'(HSW * VT));
        checkEq("disVsLowCnt", 32'(vsLowCnt), 32'(VSW * HT));

        // Random VideoEn.
        runCycles(2 * FT, 2);

        // Mid-frame reset with a base pending.
        runTo(3, 0);
        setInputs(0);
        baseLoad = 1'b1;
        tick();
        runCycles($urandom_range(FT / 3, FT / 2), 0);
        checkEq("midPendBefore", 32'(pend0), 32'd1);
        setInputs(0);
        resetN = 1'b0;
        tick();
        checkEq("midRstReq", 32'(req0), 32'd0);
        checkEq("midRstPend", 32'(pend1), 32'd0);
        resetN = 1'b1;
        setInputs(0);
        tick();
        checkEq("midRestartAddr1", 32'(addr1), 32'(BASE1));
        runCycles(FT, 0);

        // Final random traffic.
        runCycles(2 * FT, 1);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
